// File: rtl/fb_id_ex_stage_pkg.sv
// Shared constants and types for the Firebird ID/EX stage: ALU op encodings,
// opcodes, width defaults and the CU control bundle.
package fb_id_ex_stage_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned CTRL_W     = 10;

  localparam logic [1:0] ALU_OP_R   = 2'b10;
  localparam logic [1:0] ALU_OP_B   = 2'b01;
  localparam logic [1:0] ALU_OP_MEM = 2'b00;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       alu_res_src;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_src;
  } ctrl_t;

  typedef enum logic [1:0] {
    UPD_LOAD,
    UPD_HOLD,
    UPD_BUBBLE,
    UPD_FLUSH
  } upd_e;

  // An invalid slot must never carry state-changing side effects downstream.
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
    ctrl_t g;
    g = c;
    if (!valid) begin
      g.mem_read  = 1'b0;
      g.mem_write = 1'b0;
      g.reg_write = 1'b0;
      g.branch    = 1'b0;
      g.pc_src    = 1'b0;
    end
    return g;
  endfunction

endpackage

// File: rtl/fb_id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detector: a valid ID instruction reads the
// destination of a valid load sitting in EX (x0 excluded).
module fb_load_use_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              haz
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  assign haz     = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/fb_id_ex_stage.sv
// Firebird ID/EX pipeline register with load-use bubble insertion, EX flush,
// downstream stall and a saturating bubble counter.
module fb_id_ex_stage
  import fb_id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [1:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_alu_res_src,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic              id_pc_src,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7b5,
  input  logic              ex_flush,
  input  logic              ext_stall,
  input  logic              cnt_clr,
  output logic              ex_valid,
  output logic [1:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_alu_res_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_pc_src,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_uses_rs1,
  output logic              ex_uses_rs2,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output logic              id_stall,
  output logic              hazard_bubble,
  output logic [CNT_W-1:0]  bubble_cnt
);

  ctrl_t             id_ctrl;
  ctrl_t             ctrl_d, ctrl_q;
  logic              valid_d, valid_q;
  logic [XLEN-1:0]   pc_d, pc_q, rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q, imm_d, imm_q;
  logic [REG_AW-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic              uses_rs1_d, uses_rs1_q, uses_rs2_d, uses_rs2_q;
  logic [2:0]        funct3_d, funct3_q;
  logic              funct7b5_d, funct7b5_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              haz;
  upd_e              upd;

  assign id_ctrl = '{alu_op: id_alu_op, alu_src: id_alu_src, alu_res_src: id_alu_res_src,
                     mem_read: id_mem_read, mem_write: id_mem_write, branch: id_branch,
                     mem_to_reg: id_mem_to_reg, reg_write: id_reg_write, pc_src: id_pc_src};

  fb_load_use_detect #(.REG_AW(REG_AW)) u_luse (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (rd_q),
    .haz         (haz)
  );

  assign hazard_bubble = haz && !ex_flush && !ext_stall;
  assign id_stall      = !ex_flush && (ext_stall || haz);

  always_comb begin
    if (ex_flush)       upd = UPD_FLUSH;
    else if (ext_stall) upd = UPD_HOLD;
    else if (haz)       upd = UPD_BUBBLE;
    else                upd = UPD_LOAD;
  end

  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    uses_rs1_d = uses_rs1_q;
    uses_rs2_d = uses_rs2_q;
    funct3_d   = funct3_q;
    funct7b5_d = funct7b5_q;
    unique case (upd)
      UPD_FLUSH, UPD_BUBBLE: begin
        valid_d    = 1'b0;
        ctrl_d     = '0;
        pc_d       = '0;
        rs1_data_d = '0;
        rs2_data_d = '0;
        imm_d      = '0;
        rs1_d      = '0;
        rs2_d      = '0;
        rd_d       = '0;
        uses_rs1_d = 1'b0;
        uses_rs2_d = 1'b0;
        funct3_d   = '0;
        funct7b5_d = 1'b0;
      end
      UPD_LOAD: begin
        valid_d    = id_valid;
        ctrl_d     = gate_ctrl(id_ctrl, id_valid);
        pc_d       = id_pc;
        rs1_data_d = id_rs1_data;
        rs2_data_d = id_rs2_data;
        imm_d      = id_imm;
        rs1_d      = id_rs1;
        rs2_d      = id_rs2;
        rd_d       = id_rd;
        uses_rs1_d = id_uses_rs1;
        uses_rs2_d = id_uses_rs2;
        funct3_d   = id_funct3;
        funct7b5_d = id_funct7b5;
      end
      default: ;
    endcase
  end

  // Clear beats increment; the counter saturates rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                           cnt_d = '0;
    else if (hazard_bubble && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      uses_rs1_q <= 1'b0;
      uses_rs2_q <= 1'b0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      uses_rs1_q <= uses_rs1_d;
      uses_rs2_q <= uses_rs2_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_alu_op      = ctrl_q.alu_op;
  assign ex_alu_src     = ctrl_q.alu_src;
  assign ex_alu_res_src = ctrl_q.alu_res_src;
  assign ex_mem_read    = ctrl_q.mem_read;
  assign ex_mem_write   = ctrl_q.mem_write;
  assign ex_branch      = ctrl_q.branch;
  assign ex_mem_to_reg  = ctrl_q.mem_to_reg;
  assign ex_reg_write   = ctrl_q.reg_write;
  assign ex_pc_src      = ctrl_q.pc_src;
  assign ex_pc          = pc_q;
  assign ex_rs1_data    = rs1_data_q;
  assign ex_rs2_data    = rs2_data_q;
  assign ex_imm         = imm_q;
  assign ex_rs1         = rs1_q;
  assign ex_rs2         = rs2_q;
  assign ex_rd          = rd_q;
  assign ex_uses_rs1    = uses_rs1_q;
  assign ex_uses_rs2    = uses_rs2_q;
  assign ex_funct3      = funct3_q;
  assign ex_funct7b5    = funct7b5_q;
  assign bubble_cnt     = cnt_q;

endmodule

// File: tb/tb_fb_id_ex_stage.sv
// Directed bench for fb_id_ex_stage; a second instance with a 2-bit counter
// shares all inputs and exercises counter saturation.
module tb_fb_id_ex_stage;

  logic        clk, rst;
  logic        id_valid, id_alu_src, id_alu_res_src, id_mem_read, id_mem_write;
  logic        id_branch, id_mem_to_reg, id_reg_write, id_pc_src;
  logic [1:0]  id_alu_op;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2, id_funct7b5;
  logic [2:0]  id_funct3;
  logic        ex_flush, ext_stall, cnt_clr;

  logic        ex_valid, ex_alu_src, ex_alu_res_src, ex_mem_read, ex_mem_write;
  logic        ex_branch, ex_mem_to_reg, ex_reg_write, ex_pc_src;
  logic [1:0]  ex_alu_op;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_uses_rs1, ex_uses_rs2, ex_funct7b5;
  logic [2:0]  ex_funct3;
  logic        id_stall, hazard_bubble;
  logic [15:0] bubble_cnt;

  logic        s_valid, s_alu_src, s_alu_res_src, s_mem_read, s_mem_write;
  logic        s_branch, s_mem_to_reg, s_reg_write, s_pc_src;
  logic [1:0]  s_alu_op;
  logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic        s_uses_rs1, s_uses_rs2, s_funct7b5;
  logic [2:0]  s_funct3;
  logic        s_id_stall, s_hazard_bubble;
  logic [1:0]  s_bubble_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  fb_id_ex_stage #(.XLEN(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_alu_res_src(id_alu_res_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
    .id_pc_src(id_pc_src), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .ex_flush(ex_flush), .ext_stall(ext_stall), .cnt_clr(cnt_clr),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_alu_res_src(ex_alu_res_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_pc_src(ex_pc_src), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_uses_rs1(ex_uses_rs1),
    .ex_uses_rs2(ex_uses_rs2), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .id_stall(id_stall), .hazard_bubble(hazard_bubble), .bubble_cnt(bubble_cnt)
  );

  fb_id_ex_stage #(.XLEN(32), .REG_AW(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_alu_res_src(id_alu_res_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
    .id_pc_src(id_pc_src), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .ex_flush(ex_flush), .ext_stall(ext_stall), .cnt_clr(cnt_clr),
    .ex_valid(s_valid), .ex_alu_op(s_alu_op), .ex_alu_src(s_alu_src),
    .ex_alu_res_src(s_alu_res_src), .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write),
    .ex_branch(s_branch), .ex_mem_to_reg(s_mem_to_reg), .ex_reg_write(s_reg_write),
    .ex_pc_src(s_pc_src), .ex_pc(s_pc), .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data),
    .ex_imm(s_imm), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_uses_rs1(s_uses_rs1),
    .ex_uses_rs2(s_uses_rs2), .ex_funct3(s_funct3), .ex_funct7b5(s_funct7b5),
    .id_stall(s_id_stall), .hazard_bubble(s_hazard_bubble), .bubble_cnt(s_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                       input logic u2, input logic [1:0] op, input logic ld, input logic wr);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_alu_op = op;
    id_mem_read = ld; id_mem_to_reg = ld; id_alu_src = ld; id_reg_write = wr;
    id_alu_res_src = 1'b0; id_mem_write = 1'b0; id_branch = 1'b0; id_pc_src = 1'b0;
    id_rs1_data = 32'hA000_0000 | {27'd0, rs1};
    id_rs2_data = 32'hB000_0000 | {27'd0, rs2};
    id_imm = pc ^ 32'h55;
    id_funct3 = ld ? 3'b010 : 3'b000;
    id_funct7b5 = 1'b0;
  endtask

  task automatic lw(input logic [4:0] rd, input logic [31:0] pc);
    drive(1'b1, pc, 5'd2, 5'd0, rd, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
  endtask

  task automatic add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [31:0] pc);
    drive(1'b1, pc, rs1, rs2, rd, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_flush = 1'b0; ext_stall = 1'b0; cnt_clr = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", ex_valid); end
    n_vec++; if (ex_pc !== 32'd0) begin n_err++; $display("FAIL reset_pc got=%h exp=0", ex_pc); end
    n_vec++; if (bubble_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt); end
    n_vec++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", id_stall); end
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    @(negedge clk); add(5'd6, 5'd5, 5'd1, 32'h40);
    #1;
    n_vec++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL pass_stall got=%b exp=0", id_stall); end
    step();
    n_vec++; if (ex_pc !== 32'h40) begin n_err++; $display("FAIL pass_pc got=%h exp=00000040", ex_pc); end
    n_vec++; if (ex_rd !== 5'd6) begin n_err++; $display("FAIL pass_rd got=%0d exp=6", ex_rd); end
    n_vec++; if (ex_alu_op !== 2'b10) begin n_err++; $display("FAIL pass_aluop got=%b exp=10", ex_alu_op); end
    n_vec++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL pass_valid got=%b exp=1", ex_valid); end
    n_vec++; if (ex_reg_write !== 1'b1) begin n_err++; $display("FAIL pass_regwr got=%b exp=1", ex_reg_write); end
    n_vec++; if (ex_rs2_data !== 32'hB000_0001) begin n_err++; $display("FAIL pass_rs2d got=%h exp=b0000001", ex_rs2_data); end
    n_vec++; if (ex_imm !== 32'h15) begin n_err++; $display("FAIL pass_imm got=%h exp=00000015", ex_imm); end
  endtask

  task automatic test_load_use();
    @(negedge clk); lw(5'd5, 32'h44);
    #1;
    n_vec++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL lu_pre_stall got=%b exp=0", id_stall); end
    step();
    n_vec++; if (ex_funct3 !== 3'b010) begin n_err++; $display("FAIL lu_lw_f3 got=%b exp=010", ex_funct3); end
    @(negedge clk); add(5'd6, 5'd5, 5'd1, 32'h48);
    #1;
    n_vec++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got=%b exp=1", id_stall); end
    n_vec++; if (hazard_bubble !== 1'b1) begin n_err++; $display("FAIL lu_bubble got=%b exp=1", hazard_bubble); end
    step();
    n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL lu_bub_valid got=%b exp=0", ex_valid); end
    n_vec++; if (ex_reg_write !== 1'b0) begin n_err++; $display("FAIL lu_bub_regwr got=%b exp=0", ex_reg_write); end
    n_vec++; if (ex_mem_read !== 1'b0) begin n_err++; $display("FAIL lu_bub_memrd got=%b exp=0", ex_mem_read); end
    n_vec++; if (bubble_cnt !== 16'd1) begin n_err++; $display("FAIL lu_cnt got=%0d exp=1", bubble_cnt); end
    n_vec++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL lu_release got=%b exp=0", id_stall); end
    step();
    n_vec++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL lu_add_valid got=%b exp=1", ex_valid); end
    n_vec++; if (ex_rs1 !== 5'd5) begin n_err++; $display("FAIL lu_add_rs1 got=%0d exp=5", ex_rs1); end
    n_vec++; if (ex_pc !== 32'h48) begin n_err++; $display("FAIL lu_add_pc got=%h exp=00000048", ex_pc); end
    n_vec++; if (bubble_cnt !== 16'd1) begin n_err++; $display("FAIL lu_cnt_once got=%0d exp=1", bubble_cnt); end
  endtask

  task automatic test_invalid_gating();
    @(negedge clk);
    drive(1'b0, 32'h80, 5'd1, 5'd1, 5'd7, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1);
    id_mem_write = 1'b1; id_branch = 1'b1; id_pc_src = 1'b1;
    step();
    n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL inv_valid got=%b exp=0", ex_valid); end
    n_vec++; if ({ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_pc_src} !== 5'b0)
      begin n_err++; $display("FAIL inv_gate got=%b exp=00000", {ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_pc_src}); end
    n_vec++; if (ex_mem_to_reg !== 1'b1) begin n_err++; $display("FAIL inv_m2r got=%b exp=1", ex_mem_to_reg); end
    n_vec++; if (ex_pc !== 32'h80) begin n_err++; $display("FAIL inv_pc got=%h exp=00000080", ex_pc); end
  endtask

  task automatic test_x0_unused();
    @(negedge clk); lw(5'd0, 32'h90);
    step();
    @(negedge clk); add(5'd6, 5'd0, 5'd0, 32'h94);
    #1;
    n_vec++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL x0_stall got=%b exp=0", id_stall); end
    n_vec++; if (hazard_bubble !== 1'b0) begin n_err++; $display("FAIL x0_bubble got=%b exp=0", hazard_bubble); end
    step();
    n_vec++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin n_err++; $display("FAIL x0_adv got=%b/%0d exp=1/6", ex_valid, ex_rd); end
    n_vec++; if (bubble_cnt !== 16'd1) begin n_err++; $display("FAIL x0_cnt got=%0d exp=1", bubble_cnt); end
    @(negedge clk); lw(5'd5, 32'hA0);
    step();
    @(negedge clk); drive(1'b1, 32'hA4, 5'd5, 5'd1, 5'd7, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
    #1;
    n_vec++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL unused_stall got=%b exp=0", id_stall); end
    step();
    n_vec++; if (ex_valid !== 1'b1 || bubble_cnt !== 16'd1) begin n_err++; $display("FAIL unused_adv got=%b/%0d exp=1/1", ex_valid, bubble_cnt); end
  endtask

  task automatic test_flush();
    @(negedge clk); lw(5'd5, 32'hB0);
    step();
    @(negedge clk); add(5'd6, 5'd5, 5'd1, 32'hB4); ex_flush = 1'b1;
    #1;
    n_vec++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL fl_stall got=%b exp=0", id_stall); end
    n_vec++; if (hazard_bubble !== 1'b0) begin n_err++; $display("FAIL fl_bubble got=%b exp=0", hazard_bubble); end
    step();
    n_vec++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0) begin n_err++; $display("FAIL fl_clear got=%b/%0d exp=0/0", ex_valid, ex_rd); end
    n_vec++; if (bubble_cnt !== 16'd1) begin n_err++; $display("FAIL fl_cnt got=%0d exp=1", bubble_cnt); end
    @(negedge clk); ex_flush = 1'b0;
  endtask

  task automatic test_ext_stall();
    @(negedge clk); lw(5'd5, 32'h100);
    step();
    @(negedge clk); add(5'd6, 5'd5, 5'd1, 32'h104); ext_stall = 1'b1;
    #1;
    n_vec++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL st_stall got=%b exp=1", id_stall); end
    n_vec++; if (hazard_bubble !== 1'b0) begin n_err++; $display("FAIL st_bubble got=%b exp=0", hazard_bubble); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || ex_rd !== 5'd5 || ex_mem_read !== 1'b1)
        begin n_err++; $display("FAIL st_hold%0d got=%b/%h/%0d/%b exp=1/00000100/5/1", i, ex_valid, ex_pc, ex_rd, ex_mem_read); end
      n_vec++; if (bubble_cnt !== 16'd1) begin n_err++; $display("FAIL st_cnt%0d got=%0d exp=1", i, bubble_cnt); end
    end
    @(negedge clk); ext_stall = 1'b0;
    #1;
    n_vec++; if (hazard_bubble !== 1'b1) begin n_err++; $display("FAIL st_rel_bubble got=%b exp=1", hazard_bubble); end
    step();
    n_vec++; if (ex_valid !== 1'b0 || bubble_cnt !== 16'd2) begin n_err++; $display("FAIL st_bub got=%b/%0d exp=0/2", ex_valid, bubble_cnt); end
    step();
    n_vec++; if (ex_valid !== 1'b1 || ex_pc !== 32'h104 || bubble_cnt !== 16'd2)
      begin n_err++; $display("FAIL st_adv got=%b/%h/%0d exp=1/00000104/2", ex_valid, ex_pc, bubble_cnt); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid got=%b exp=0", ex_valid); end
    n_vec++; if (ex_pc !== 32'd0 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0)
      begin n_err++; $display("FAIL ar_regs got=%h/%b/%0d exp=0/0/0", ex_pc, ex_reg_write, ex_rd); end
    n_vec++; if (bubble_cnt !== 16'd0) begin n_err++; $display("FAIL ar_cnt got=%0d exp=0", bubble_cnt); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0]  exp_s;
    logic [15:0] exp_m;
    for (int k = 1; k <= 5; k++) begin
      exp_m = 16'(k);
      exp_s = (k < 3) ? 2'(k) : 2'd3;
      @(negedge clk); lw(5'd5, 32'h200);
      step();
      @(negedge clk); add(5'd6, 5'd5, 5'd1, 32'h204);
      step();
      n_vec++; if (s_bubble_cnt !== exp_s) begin n_err++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", k, s_bubble_cnt, exp_s); end
      n_vec++; if (bubble_cnt !== exp_m) begin n_err++; $display("FAIL sat_main%0d got=%0d exp=%0d", k, bubble_cnt, exp_m); end
      step();
      n_vec++; if (s_bubble_cnt !== exp_s) begin n_err++; $display("FAIL sat_hold%0d got=%0d exp=%0d", k, s_bubble_cnt, exp_s); end
    end
    @(negedge clk); lw(5'd5, 32'h300);
    step();
    @(negedge clk); add(5'd6, 5'd5, 5'd1, 32'h304); cnt_clr = 1'b1;
    #1;
    n_vec++; if (hazard_bubble !== 1'b1) begin n_err++; $display("FAIL clr_bubble got=%b exp=1", hazard_bubble); end
    step();
    n_vec++; if (s_bubble_cnt !== 2'd0) begin n_err++; $display("FAIL clr_sat got=%0d exp=0", s_bubble_cnt); end
    n_vec++; if (bubble_cnt !== 16'd0) begin n_err++; $display("FAIL clr_main got=%0d exp=0", bubble_cnt); end
    @(negedge clk); cnt_clr = 1'b0;
    step();
    n_vec++; if (ex_valid !== 1'b1 || bubble_cnt !== 16'd0) begin n_err++; $display("FAIL clr_adv got=%b/%0d exp=1/0", ex_valid, bubble_cnt); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_use();
    test_invalid_gating();
    test_x0_unused();
    test_flush();
    test_ext_stall();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
